cpec_stream_packer: RTL and testbench
=====================================

Name: cpec_stream_packer

Overview:
- Sequential, parametrised successor to the combinational CPEC group encoder.
- Accepts one group of G signed J-bit residual samples per handshake and CPEC-encodes each sample to bits_req bits: two's-complement LSBs when ecgidx==3, otherwise magnitude LSBs.
- Packs the codes MSB-first into a bit accumulator and emits fixed OUT_W-bit words over a valid/ready stream to the bitstream assembler.
- Supports flush, which emits a zero-padded final word.

Parameters:
- J, 10, sample width in bits (signed).
- G, 4, samples per group.
- OUT_W, 16, output word width. Must satisfy OUT_W >= J.
- ACC_W, OUT_W+G*J-1, accumulator width. Derived; not to be overridden.
- NB_W, $clog2(OUT_W+1), width of out_nbits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  group input valid.
- in_ready  out  1  group input ready.
- in_samples  in  G*J  sample_1 in bits [G*J-1 -: J], sample_G in bits [J-1:0]; signed.
- in_ecgidx  in  2  value 3 selects two's complement; any other value selects SM magnitude.
- in_bits_req  in  4  bits per sample; legal range 3..J.
- in_skip  in  1  group skip flag.
- flush  in  1  single-cycle request to drain the accumulator.
- out_valid  out  1  output word valid.
- out_ready  in  1  output word ready.
- out_data  out  OUT_W  packed word; the oldest bit is at the MSB.
- out_nbits  out  NB_W  number of meaningful bits in out_data: OUT_W, or fewer on a last word.
- out_last  out  1  marks the final padded word of a flush.
- err_bits_req  out  1  one-cycle pulse on accepting an illegal bits_req.

Behaviour:
- Reset (synchronous, active-high) clears the accumulator, acc_cnt, and flush_pend.
  - While rst is high, all outputs are 0: in_ready=0, out_valid=0, out_data=0, out_nbits=0, out_last=0, err_bits_req=0.
  - Reset mid-operation discards all buffered bits; no partial word is emitted.
- States:
  - S_FILL: acc_cnt < OUT_W and no flush pending.
  - S_EMIT: acc_cnt >= OUT_W.
  - S_FLUSH: flush pending and 0 < acc_cnt < OUT_W.
  - The state is derived from registers and updated every cycle.
- in_ready = !rst && acc_cnt < OUT_W && !flush_pend. This guarantees an accepted group always fits in ACC_W.
- Group accept (in_valid && in_ready), takes effect at the next edge:
  - in_skip=1: contributes 0 bits. A skip group is always legal and never raises err_bits_req.
  - bits_req outside 3..J (and in_skip=0): contributes 0 bits; err_bits_req pulses on the following cycle.
  - Otherwise, for each sample k=1..G, code_k is:
    - ecgidx==3: sample_k[b-1:0].
    - else: |sample_k|[b-1:0]. For the most-negative input, |x| wraps to 2^(J-1); there is no saturation.
  - Append code_1..code_G after the existing bits, sample_1 first; acc_cnt += G*b.
- Word emit:
  - out_valid=1 whenever acc_cnt >= OUT_W.
  - out_data = the oldest OUT_W bits; out_nbits=OUT_W; out_last=0.
  - On out_ready: shift out OUT_W bits; acc_cnt -= OUT_W.
- Flush:
  - flush=1 sets flush_pend, which stays sticky.
  - Full words drain first.
  - Then, if 0 < acc_cnt < OUT_W: out_valid=1, out_data = remaining bits left-aligned with zero padding, out_nbits=acc_cnt, out_last=1.
  - On the handshake of that padded word: acc_cnt=0 and flush_pend clears.
  - If acc_cnt==0 once full words are drained, flush_pend clears with no word emitted.
  - A flush asserted together with an accepted group applies after that group is appended.
- Latency: a group accepted at edge t can present out_valid in the cycle after edge t (1 cycle).
- Stability: out_data, out_nbits and out_last hold constant while out_valid && !out_ready.
- Simultaneous input and output handshake cannot occur, since in_ready=0 whenever a word is pending. The bench checks this as an assertion.

Optional Feature:
- Macro: CPEC_BITCOUNT_EN.
- When defined:
  - Adds output port bit_count (out, 32): the running total of meaningful bits emitted, incremented by out_nbits on each output handshake.
  - Cleared by rst; wraps modulo 2^32.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- T1, two's complement: ecgidx=3, bits_req=4, samples {1,-1,5,-8} → next cycle out_valid, out_data=0x1F58, out_nbits=16, in_ready low until out_ready.
- T2, SM mode: ecgidx=0, bits_req=4, samples {-3,2,-7,1} → out_data=0x3271.
- T3, packing plus flush:
  - bits_req=3, samples {1,1,1,1}: no output, acc_cnt=12.
  - Then {2,2,2,2} → word 0x2494, acc_cnt=8.
  - Then flush → out_data=0x9200, out_nbits=8, out_last=1, then acc_cnt=0.
- T4, skip and illegal values: in_skip=1 (any bits_req) → no bits, no err. bits_req=2, then bits_req=11 → err_bits_req pulses once each, acc_cnt unchanged.
- T5, backpressure: hold out_ready=0 for 10 cycles after T1 → out_data stable at 0x1F58, in_ready=0, no group lost. Release → one handshake.
- T6, reset mid-op: after the first T3 group, assert rst for 1 cycle → acc_cnt=0, no output. A subsequent flush emits nothing. Under CPEC_BITCOUNT_EN, bit_count=0, and 40 after T1+T3.

Source files
------------

// File: rtl/cpec_stream_packer.sv
// cpec_stream_packer
// Accepts one group of G signed J-bit residuals per handshake, CPEC-encodes
// each sample to bits_req bits (two's-complement LSBs for ecgidx==3, magnitude
// LSBs otherwise), packs the codes MSB-first into a bit accumulator and emits
// fixed OUT_W-bit words on a valid/ready stream. A flush drains the
// accumulator and emits a zero-padded final word flagged with out_last.
//
// Optional feature macro: CPEC_BITCOUNT_EN
//   When defined, adds a 32-bit bit_count output holding the running total of
//   meaningful bits handed to the consumer (wraps modulo 2^32).
//
// Accumulator layout: the oldest bit is always at acc_q[ACC_W-1]. Every bit
// below the acc_cnt valid bits is kept at zero, so the padded flush word is
// simply the top OUT_W bits of the accumulator.
//
// OUT_W must be >= J; ACC_W is derived and must not be overridden.
module cpec_stream_packer #(
   parameter int J     = 10,
   parameter int G     = 4,
   parameter int OUT_W = 16,
   parameter int ACC_W = OUT_W + G*J - 1,
   parameter int NB_W  = $clog2(OUT_W+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [G*J-1:0]    in_samples,
   input  logic [1:0]        in_ecgidx,
   input  logic [3:0]        in_bits_req,
   input  logic              in_skip,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [NB_W-1:0]   out_nbits,
   output logic              out_last,
   output logic              err_bits_req
`ifdef CPEC_BITCOUNT_EN
   ,
   output logic [31:0]       bit_count
`endif
);

   localparam int GW    = G*J;
   localparam int CNT_W = $clog2(ACC_W+1);

   localparam logic [CNT_W-1:0] OUT_C     = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] ACC_C     = CNT_W'(ACC_W);
   localparam logic [4:0]       BREQ_MIN  = 5'd3;
   localparam logic [4:0]       BREQ_MAX  = 5'(J);

   // Derived operating state; recomputed from the registers every cycle.
   typedef enum logic [1:0] {
      S_FILL  = 2'd0,   // collecting bits, no flush pending
      S_EMIT  = 2'd1,   // at least one full word buffered
      S_FLUSH = 2'd2,   // flush pending, a partial word remains
      S_DONE  = 2'd3    // flush pending, nothing left: clear the request
   } state_e;

   // CPEC code of one sample: selected representation masked to b LSBs.
   // The magnitude of the most-negative input wraps to 2^(J-1) (no saturation).
   function automatic logic [J-1:0] cpec_code(
      input logic [J-1:0] smp,
      input logic [1:0]   ecg,
      input logic [3:0]   b
   );
      logic [J-1:0] mag;
      logic [J-1:0] mask;
      mag  = smp[J-1] ? (~smp + {{(J-1){1'b0}}, 1'b1}) : smp;
      mask = ~({J{1'b1}} << b);
      if (ecg == 2'd3) begin
         return smp & mask;
      end else begin
         return mag & mask;
      end
   endfunction

   // Registers
   logic [ACC_W-1:0] acc_q,  acc_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic             pend_q, pend_d;
   logic             err_q,  err_d;

   // Combinational helpers
   state_e           state_s;
   logic [GW-1:0]    grp_s;
   logic [CNT_W-1:0] grp_bits_s;
   logic [CNT_W-1:0] shift_s;
   logic             bits_ok_s;
   logic             in_fire_s;
   logic             out_fire_s;

   // Classify the current operating state from acc_cnt and the flush request.
   always_comb begin
      state_s = S_FILL;
      if (cnt_q >= OUT_C) begin
         state_s = S_EMIT;
      end else if (pend_q && (cnt_q != '0)) begin
         state_s = S_FLUSH;
      end else if (pend_q) begin
         state_s = S_DONE;
      end else begin
         state_s = S_FILL;
      end
   end

   // Input may only be taken while no word is waiting, so a group always fits.
   assign in_ready   = !rst && (cnt_q < OUT_C) && !pend_q;
   assign in_fire_s  = in_valid && in_ready;
   assign out_fire_s = out_valid && out_ready;

   // Legal code width is 3..J bits.
   assign bits_ok_s = ({1'b0, in_bits_req} >= BREQ_MIN) &&
                      ({1'b0, in_bits_req} <= BREQ_MAX);

   // Encode the group and concatenate the codes, sample_1 ending up oldest.
   always_comb begin
      grp_s      = '0;
      grp_bits_s = '0;
      for (int k = 0; k < G; k++) begin
         grp_s      = (grp_s << in_bits_req) |
                      GW'(cpec_code(in_samples[GW-1-k*J -: J], in_ecgidx, in_bits_req));
         grp_bits_s = grp_bits_s + CNT_W'(in_bits_req);
      end
   end

   // Left shift that lands the new group directly behind the buffered bits.
   assign shift_s = ACC_C - grp_bits_s - cnt_q;

   // Next-state logic for the accumulator, its fill count and flush request.
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      err_d  = 1'b0;
      if (in_fire_s) begin
         if (in_skip) begin
            acc_d = acc_q;
         end else if (!bits_ok_s) begin
            err_d = 1'b1;
         end else begin
            acc_d = acc_q | (ACC_W'(grp_s) << shift_s);
            cnt_d = cnt_q + grp_bits_s;
         end
      end else if (out_fire_s) begin
         case (state_s)
            S_EMIT: begin
               acc_d = acc_q << OUT_W;
               cnt_d = cnt_q - OUT_C;
            end
            S_FLUSH: begin
               acc_d  = '0;
               cnt_d  = '0;
               pend_d = 1'b0;
            end
            default: begin
               acc_d = acc_q;
            end
         endcase
      end else if (state_s == S_DONE) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
      // A new flush request lands after any group accepted in the same cycle.
      if (flush) begin
         pend_d = 1'b1;
      end else begin
         pend_d = pend_d;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         pend_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   // Output word view of the registered accumulator; forced to zero in reset.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_nbits = '0;
      out_last  = 1'b0;
      if (!rst) begin
         case (state_s)
            S_EMIT: begin
               out_valid = 1'b1;
               out_data  = acc_q[ACC_W-1 -: OUT_W];
               out_nbits = NB_W'(OUT_W);
               out_last  = 1'b0;
            end
            S_FLUSH: begin
               out_valid = 1'b1;
               out_data  = acc_q[ACC_W-1 -: OUT_W];
               out_nbits = NB_W'(cnt_q);
               out_last  = 1'b1;
            end
            default: begin
               out_valid = 1'b0;
            end
         endcase
      end else begin
         out_valid = 1'b0;
      end
   end

   assign err_bits_req = err_q && !rst;

`ifdef CPEC_BITCOUNT_EN
   logic [31:0] bitcnt_q, bitcnt_d;

   // Running total of meaningful bits handed over on output handshakes.
   always_comb begin
      if (out_fire_s) begin
         bitcnt_d = bitcnt_q + 32'(out_nbits);
      end else begin
         bitcnt_d = bitcnt_q;
      end
   end

   // Bit counter register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bitcnt_q <= 32'd0;
      end else begin
         bitcnt_q <= bitcnt_d;
      end
   end

   assign bit_count = rst ? 32'd0 : bitcnt_q;
`endif

endmodule

// File: tb/tb_cpec_stream_packer.sv
// Directed, table-driven bench for cpec_stream_packer (J=10, G=4, OUT_W=16).
module tb_cpec_stream_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [39:0] in_samples = '0;
   logic [1:0]  in_ecgidx = 2'd0;
   logic [3:0]  in_bits_req = 4'd0;
   logic        in_skip = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [4:0]  out_nbits;
   logic        out_last;
   logic        err_bits_req;
`ifdef CPEC_BITCOUNT_EN
   logic [31:0] bit_count;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int n_overlap = 0;

   cpec_stream_packer dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_samples   (in_samples),
      .in_ecgidx    (in_ecgidx),
      .in_bits_req  (in_bits_req),
      .in_skip      (in_skip),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_nbits    (out_nbits),
      .out_last     (out_last),
      .err_bits_req (err_bits_req)
`ifdef CPEC_BITCOUNT_EN
      ,
      .bit_count    (bit_count)
`endif
   );

   always #5 clk = ~clk;

   // Input and output handshakes must never coincide.
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready && out_valid && out_ready) begin
         n_overlap = n_overlap + 1;
      end
   end

   // Global time limit.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  ecg;
      logic [3:0]  b;
      logic [39:0] smp;
      logic        skip;
      logic        fl;
      logic        err;
      int          nw;
      logic [47:0] w;
      logic [14:0] n;
      logic [2:0]  l;
   } vec_t;

   vec_t vt[11];

   function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
      return {10'(a), 10'(b), 10'(c), 10'(d)};
   endfunction

   function automatic vec_t mk(input logic [1:0] ecg, input logic [3:0] b, input logic [39:0] smp,
                               input logic skip, input logic fl, input logic err, input int nw,
                               input logic [47:0] w, input logic [14:0] n, input logic [2:0] l);
      vec_t v;
      v.ecg = ecg; v.b = b; v.smp = smp; v.skip = skip; v.fl = fl; v.err = err;
      v.nw = nw; v.w = w; v.n = n; v.l = l;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Present one group for one accepted cycle (bounded wait for in_ready).
   task automatic drive_group(input logic [1:0] ecg, input logic [3:0] b, input logic [39:0] smp,
                              input logic skip, input logic fl);
      int t;
      t = 0;
      while (!in_ready && t < 20) begin
         tick();
         t++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_ecgidx = ecg; in_bits_req = b; in_samples = smp;
      in_skip = skip; flush = fl;
      tick();
      in_valid = 1'b0; in_skip = 1'b0; flush = 1'b0;
   endtask

   // Check the presented word, then take it with a one-cycle out_ready.
   task automatic pop(input string name, input logic [15:0] d, input logic [4:0] nb, input logic last);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, 32'(out_data), 32'(d));
      chk({name, "_nbits"}, 32'(out_nbits), 32'(nb));
      chk({name, "_last"}, 32'(out_last), 32'(last));
      chk({name, "_inrdy"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // Two 3-bit groups then a flush: 0x2494 then padded 0x9200 (8 bits).
   task automatic run_t3();
      drive_group(2'd3, 4'd3, pk(1, 1, 1, 1), 1'b0, 1'b0);
      chk("t3_g1_novalid", 32'(out_valid), 32'd0);
      chk("t3_g1_inrdy", 32'(in_ready), 32'd1);
      drive_group(2'd3, 4'd3, pk(2, 2, 2, 2), 1'b0, 1'b0);
      pop("t3_w1", 16'h2494, 5'd16, 1'b0);
      chk("t3_rem_novalid", 32'(out_valid), 32'd0);
      chk("t3_rem_inrdy", 32'(in_ready), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      pop("t3_pad", 16'h9200, 5'd8, 1'b1);
      chk("t3_empty_valid", 32'(out_valid), 32'd0);
      chk("t3_empty_inrdy", 32'(in_ready), 32'd1);
   endtask

   initial begin
      vt[0]  = mk(2'd3, 4'd4,  pk(1, -1, 5, -8),        1'b0, 1'b0, 1'b0, 1, {16'h1F58, 32'h0}, {5'd16, 10'd0}, 3'b000);
      vt[1]  = mk(2'd0, 4'd4,  pk(-3, 2, -7, 1),        1'b0, 1'b0, 1'b0, 1, {16'h3271, 32'h0}, {5'd16, 10'd0}, 3'b000);
      vt[2]  = mk(2'd1, 4'd4,  pk(-8, 7, -1, 0),        1'b0, 1'b0, 1'b0, 1, {16'h8710, 32'h0}, {5'd16, 10'd0}, 3'b000);
      vt[3]  = mk(2'd3, 4'd3,  pk(3, -4, -1, 2),        1'b0, 1'b1, 1'b0, 1, {16'h73A0, 32'h0}, {5'd12, 10'd0}, 3'b100);
      vt[4]  = mk(2'd0, 4'd10, pk(-512, -1, 511, -511), 1'b0, 1'b1, 1'b0, 3,
                  {16'h8000, 16'h17FD, 16'hFF00}, {5'd16, 5'd16, 5'd8}, 3'b001);
      vt[5]  = mk(2'd3, 4'd2,  pk(5, 5, 5, 5),          1'b1, 1'b1, 1'b0, 0, 48'h0, 15'h0, 3'b000);
      vt[6]  = mk(2'd0, 4'd2,  pk(1, 1, 1, 1),          1'b0, 1'b0, 1'b1, 0, 48'h0, 15'h0, 3'b000);
      vt[7]  = mk(2'd3, 4'd11, pk(1, 1, 1, 1),          1'b0, 1'b0, 1'b1, 0, 48'h0, 15'h0, 3'b000);
      vt[8]  = mk(2'd2, 4'd15, pk(7, 7, 7, 7),          1'b0, 1'b1, 1'b1, 0, 48'h0, 15'h0, 3'b000);
      vt[9]  = mk(2'd3, 4'd10, pk(1, 2, 3, 4),          1'b0, 1'b1, 1'b0, 3,
                  {16'h0040, 16'h200C, 16'h0400}, {5'd16, 5'd16, 5'd8}, 3'b001);
      vt[10] = mk(2'd2, 4'd5,  pk(-16, 15, -1, 16),     1'b0, 1'b1, 1'b0, 2,
                  {16'h83C3, 16'h0000, 16'h0}, {5'd16, 5'd4, 5'd0}, 3'b010);

      // Reset state: every output low while rst is high.
      rst = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_nbits", 32'(out_nbits), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_err", 32'(err_bits_req), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);

      // Table of single-group transactions, each returning to empty.
      for (int i = 0; i < 11; i++) begin
         drive_group(vt[i].ecg, vt[i].b, vt[i].smp, vt[i].skip, vt[i].fl);
         chk($sformatf("v%0d_err", i), 32'(err_bits_req), 32'(vt[i].err));
         if (vt[i].nw == 0) chk($sformatf("v%0d_novalid", i), 32'(out_valid), 32'd0);
         for (int k = 0; k < vt[i].nw; k++) begin
            pop($sformatf("v%0d_w%0d", i, k), vt[i].w[47-16*k -: 16], vt[i].n[14-5*k -: 5], vt[i].l[2-k]);
         end
         tick();
         chk($sformatf("v%0d_end_valid", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d_end_inrdy", i), 32'(in_ready), 32'd1);
         chk($sformatf("v%0d_end_err", i), 32'(err_bits_req), 32'd0);
      end

      // Backpressure: T1 word held 10 cycles while a second group waits.
      drive_group(2'd3, 4'd4, pk(1, -1, 5, -8), 1'b0, 1'b0);
      in_valid = 1'b1; in_ecgidx = 2'd0; in_bits_req = 4'd4; in_samples = pk(-3, 2, -7, 1);
      for (int c = 0; c < 10; c++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), 32'h1F58);
         chk("bp_nbits", 32'(out_nbits), 32'd16);
         chk("bp_inrdy", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      chk("bp_rel_data", 32'(out_data), 32'h1F58);
      tick();
      out_ready = 1'b0;
      chk("bp_after_valid", 32'(out_valid), 32'd0);
      chk("bp_after_inrdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      pop("bp_second", 16'h3271, 5'd16, 1'b0);
      chk("bp_done_valid", 32'(out_valid), 32'd0);

      // Packing across groups plus flush.
      run_t3();

      // Reset mid-operation discards buffered bits.
      drive_group(2'd3, 4'd3, pk(1, 1, 1, 1), 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_inrdy", 32'(in_ready), 32'd0);
      chk("t6_rst_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      tick();
      chk("t6_post_valid", 32'(out_valid), 32'd0);
`ifdef CPEC_BITCOUNT_EN
      chk("t6_bitcount_zero", bit_count, 32'd0);
`endif
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_flush_novalid", 32'(out_valid), 32'd0);
      tick();
      chk("t6_flush_novalid2", 32'(out_valid), 32'd0);
      chk("t6_flush_inrdy", 32'(in_ready), 32'd1);
      drive_group(2'd3, 4'd4, pk(1, -1, 5, -8), 1'b0, 1'b0);
      pop("t6_t1", 16'h1F58, 5'd16, 1'b0);
      run_t3();
`ifdef CPEC_BITCOUNT_EN
      chk("t6_bitcount_40", bit_count, 32'd40);
`endif

      chk("no_handshake_overlap", 32'(n_overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
